// File: rtl/seq_cla_adder.sv
// Multi-cycle adder: a CHUNK-bit carry-look-ahead slice walks the operands LSB to MSB,
// one chunk per clock. Define SEQ_CLA_ADDER_OVF_EN to add the signed-overflow output ovf.
module seq_cla_adder #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy,
`ifdef SEQ_CLA_ADDER_OVF_EN
  output logic             ovf,
`endif
  output logic [1:0]       dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid && ready; valid must not
  // depend on ready, and a source holds its data until the transfer.
  localparam int NUM_CHUNKS = WIDTH / CHUNK;
  localparam int IDXW       = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NUM_CHUNKS - 1);

  if (WIDTH % CHUNK != 0) begin : g_bad_chunk
    $error("seq_cla_adder: WIDTH must be a multiple of CHUNK");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADD  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [IDXW-1:0]   idx_q, idx_d;
  logic              carry_q, carry_d;
  logic [WIDTH-1:0]  opa_q, opa_d;
  logic [WIDTH-1:0]  opb_q, opb_d;
  logic [WIDTH-1:0]  sum_q, sum_d;
  logic              cout_q, cout_d;
`ifdef SEQ_CLA_ADDER_OVF_EN
  logic              ovf_q, ovf_d;
`endif

  logic [CHUNK-1:0]  g, p;
  logic [CHUNK:0]    c;
  logic              acc, prod;

  // Flat look-ahead: c[i+1] = g[i] | p[i]g[i-1] | ... | p[i..0]&carry, no ripple chain.
  always_comb begin
    g    = opa_q[idx_q*CHUNK +: CHUNK] & opb_q[idx_q*CHUNK +: CHUNK];
    p    = opa_q[idx_q*CHUNK +: CHUNK] ^ opb_q[idx_q*CHUNK +: CHUNK];
    c    = '0;
    acc  = 1'b0;
    prod = 1'b0;
    c[0] = carry_q;
    for (int i = 0; i < CHUNK; i++) begin
      acc  = g[i];
      prod = p[i];
      for (int j = i - 1; j >= 0; j--) begin
        acc  = acc | (prod & g[j]);
        prod = prod & p[j];
      end
      c[i+1] = acc | (prod & carry_q);
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
`ifdef SEQ_CLA_ADDER_OVF_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          opa_d   = a;
          opb_d   = b;
          carry_d = cin;
          sum_d   = '0;
          idx_d   = '0;
          state_d = S_ADD;
        end
      end
      S_ADD: begin
        sum_d[idx_q*CHUNK +: CHUNK] = p ^ c[CHUNK-1:0];
        carry_d = c[CHUNK];
        if (idx_q == LAST_IDX) begin
          cout_d  = c[CHUNK];
`ifdef SEQ_CLA_ADDER_OVF_EN
          ovf_d   = c[CHUNK] ^ c[CHUNK-1];
`endif
          state_d = S_DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      opa_q   <= '0;
      opb_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
`ifdef SEQ_CLA_ADDER_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
`ifdef SEQ_CLA_ADDER_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q == S_ADD) || (state_q == S_DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;
`ifdef SEQ_CLA_ADDER_OVF_EN
  assign ovf       = ovf_q;
`endif
  assign dbg_state = state_q;

endmodule
